// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM state encoding and line record for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int DC_LINES      = 4;
  localparam int DC_LINE_BYTES = 16;

  localparam int OFFSET_W = $clog2(DC_LINE_BYTES);
  localparam int INDEX_W  = $clog2(DC_LINES);
  localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;
  localparam int LINE_W   = 8 * DC_LINE_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } dcache_state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } dcache_line_t;

endpackage

// File: rtl/dcache_array.sv
// dcache_array: per-line valid/dirty/tag/data storage with a combinational
// read port and a single write port (full-line refill or byte/word merge).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES      = DC_LINES,
  parameter int LINE_BYTES = DC_LINE_BYTES,
  parameter int IDX_W      = INDEX_W,
  parameter int OFF_W      = OFFSET_W,
  parameter int TG_W       = TAG_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IDX_W-1:0]        index,
  output logic                    rd_valid,
  output logic                    rd_dirty,
  output logic [TG_W-1:0]         rd_tag,
  output logic [8*LINE_BYTES-1:0] rd_data,
  input  logic                    we,
  input  logic                    refill,
  input  logic [TG_W-1:0]         refill_tag,
  input  logic [8*LINE_BYTES-1:0] refill_data,
  input  logic                    merge_byte,
  input  logic [OFF_W-1:0]        merge_offset,
  input  logic [31:0]             merge_data
);

  logic [LINES-1:0]          valid_q;
  logic [LINES-1:0]          dirty_q;
  logic [TG_W-1:0]           tag_q  [LINES];
  logic [8*LINE_BYTES-1:0]   data_q [LINES];
  logic [8*LINE_BYTES-1:0]   merged_line;

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  always_comb begin
    merged_line = data_q[index];
    if (merge_byte)
      merged_line[{merge_offset, 3'b000} +: 8] = merge_data[7:0];
    else
      merged_line[{merge_offset[OFF_W-1:2], 5'b00000} +: 32] = merge_data;
  end

  // Only the status bits are cleared by reset; stale data is harmless once invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      if (refill) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) begin
      if (refill) begin
        tag_q[index]  <= refill_tag;
        data_q[index] <= refill_data;
      end else begin
        data_q[index] <= merged_line;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data-cache controller with miss FSM
// and pipeline stall. Define DCACHE_STATS_EN to add hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES      = DC_LINES,
  parameter int LINE_BYTES = DC_LINE_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MEM_R_EN,
  input  logic                    MEM_W_EN,
  input  logic                    is_byte,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    block_pipe_data_cache,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [8*LINE_BYTES-1:0] mem_wdata,
`ifdef DCACHE_STATS_EN
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
`endif
  input  logic                    mem_ack,
  input  logic [8*LINE_BYTES-1:0] mem_rdata
);

  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int INDEX_BITS  = $clog2(LINES);
  localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;
  localparam int LINE_BITS   = 8 * LINE_BYTES;

  dcache_state_t          state;
  logic                   req_q;
  logic                   we_q;
  logic [31:0]            maddr_q;
  logic [LINE_BITS-1:0]   mwdata_q;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic [31:0]            line_base;
  logic                   line_valid;
  logic                   line_dirty;
  logic [TAG_BITS-1:0]    line_tag;
  logic [LINE_BITS-1:0]   line_data;
  logic                   access;
  logic                   hit;
  logic                   idle;
  logic                   store_hit;
  logic                   refill_done;
  logic [31:0]            word;

  assign offset    = addr[OFFSET_BITS-1:0];
  assign index     = addr[OFFSET_BITS +: INDEX_BITS];
  assign tag       = addr[31 -: TAG_BITS];
  assign line_base = {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  assign access      = MEM_R_EN | MEM_W_EN;
  assign hit         = line_valid && (line_tag == tag);
  assign idle        = (state == ST_IDLE);
  assign store_hit   = !reset && idle && MEM_W_EN && hit;
  // An ack only counts once the refill request is actually on the bus.
  assign refill_done = (state == ST_REFILL) && req_q && mem_ack;

  dcache_array #(
    .LINES      (LINES),
    .LINE_BYTES (LINE_BYTES),
    .IDX_W      (INDEX_BITS),
    .OFF_W      (OFFSET_BITS),
    .TG_W       (TAG_BITS)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .index        (index),
    .rd_valid     (line_valid),
    .rd_dirty     (line_dirty),
    .rd_tag       (line_tag),
    .rd_data      (line_data),
    .we           (store_hit | refill_done),
    .refill       (refill_done),
    .refill_tag   (tag),
    .refill_data  (mem_rdata),
    .merge_byte   (is_byte),
    .merge_offset (offset),
    .merge_data   (wdata)
  );

  // Bus outputs are registered with the state so they hold through the ack cycle;
  // WRITEBACK exits with the request low, giving a one-cycle gap before refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && !hit) begin
            req_q <= 1'b1;
            if (line_valid && line_dirty) begin
              state    <= ST_WRITEBACK;
              we_q     <= 1'b1;
              maddr_q  <= {line_tag, index, {OFFSET_BITS{1'b0}}};
              mwdata_q <= line_data;
            end else begin
              state    <= ST_REFILL;
              we_q     <= 1'b0;
              maddr_q  <= line_base;
              mwdata_q <= '0;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack) begin
            state    <= ST_REFILL;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= line_base;
            mwdata_q <= '0;
          end
        end
        ST_REFILL: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (mem_ack) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            maddr_q <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = req_q & ~reset;
  assign mem_we    = we_q & ~reset;
  assign mem_addr  = reset ? '0 : maddr_q;
  assign mem_wdata = reset ? '0 : mwdata_q;

  assign block_pipe_data_cache = !reset && (!idle || (access && !hit));

  always_comb begin
    word  = line_data[{offset[OFFSET_BITS-1:2], 5'b00000} +: 32];
    rdata = '0;
    if (!reset && MEM_R_EN && hit)
      rdata = is_byte ? {24'b0, word[{offset[1:0], 3'b000} +: 8]} : word;
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (idle && access && hit)
        hit_count <= hit_count + 32'd1;
      if (idle && access && !hit)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table vectors, hand-written miss/reset sequences and a
// randomized run checked against a flat byte-memory reference.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic         clk = 1'b0;
  logic         reset, MEM_R_EN, MEM_W_EN, is_byte;
  logic [31:0]  addr, wdata, rdata, mem_addr;
  logic         block_pipe_data_cache, mem_req, mem_we, mem_ack;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .MEM_R_EN              (MEM_R_EN),
    .MEM_W_EN              (MEM_W_EN),
    .is_byte               (is_byte),
    .addr                  (addr),
    .wdata                 (wdata),
    .rdata                 (rdata),
    .block_pipe_data_cache (block_pipe_data_cache),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
`ifdef DCACHE_STATS_EN
    .hit_count             (hit_count),
    .miss_count            (miss_count),
`endif
    .mem_ack               (mem_ack),
    .mem_rdata             (mem_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Bus responder state
  logic         rst_req = 1'b1;
  logic         resp_en = 1'b1;
  logic         stray_ack = 1'b0;
  int           ack_lat = 1;
  int           req_cycles = 0;
  int           wb_count = 0;
  int           rf_count = 0;
  logic [31:0]  last_wb_addr, last_rf_addr;
  logic [127:0] last_wb_data;
  logic [127:0] bmem [int unsigned];

  // Reference: coherent byte memory plus direct-mapped residency per index
  logic [7:0]   gold [int unsigned];
  dcache_line_t mline [4];
  int           model_hits, model_misses;

  // Per-access cycle log
  int           n_cyc;
  logic         obs_req [64];
  logic         obs_we [64];
  logic         obs_stall [64];
  logic [31:0]  obs_addr [64];

  typedef struct {
    logic        rd, wr, byt;
    logic [31:0] a, wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [10];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [31:0] la);
    logic [127:0] l;
    logic [31:0]  h;
    for (int i = 0; i < 16; i++) begin
      h = (la + i) * 32'h9E3779B1;
      l[8*i +: 8] = h[31:24] ^ h[11:4];
    end
    return l;
  endfunction

  function automatic logic [127:0] get_line(input logic [31:0] la);
    if (bmem.exists(la)) return bmem[la];
    return init_line(la);
  endfunction

  function automatic logic [7:0] gold_byte(input logic [31:0] a);
    logic [127:0] l;
    if (gold.exists(a)) return gold[a];
    l = get_line({a[31:4], 4'b0});
    return l[8*a[3:0] +: 8];
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = gold_byte({a[31:2], 2'b00} + i);
    return w;
  endfunction

  function automatic logic [127:0] gold_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = gold_byte(la + i);
    return l;
  endfunction

  task automatic preset_line(input logic [31:0] la, input logic [127:0] l);
    bmem[la] = l;
    for (int i = 0; i < 16; i++) if (gold.exists(la + i)) gold.delete(la + i);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mline[i] = '0;
    model_hits = 0;
    model_misses = 0;
  endtask

  task automatic apply_store(input logic byt, input logic [31:0] a, input logic [31:0] wd);
    if (byt) gold[a] = wd[7:0];
    else for (int i = 0; i < 4; i++) gold[{a[31:2], 2'b00} + i] = wd[8*i +: 8];
    mline[a[5:4]].dirty = 1'b1;
  endtask

  // One cycle: drive at the falling edge, respond to the bus, sample 1 time unit later.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic byt,
                                input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset = rst_req;
    MEM_R_EN = rd; MEM_W_EN = wr; is_byte = byt; addr = a; wdata = wd;
    mem_ack = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (rst_req) begin
      req_cycles = 0;
    end else if (mem_req && resp_en) begin
      req_cycles++;
      if (req_cycles >= ack_lat) begin
        mem_ack = 1'b1;
        req_cycles = 0;
        if (mem_we) begin
          wb_count++;
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
          bmem[mem_addr] = mem_wdata;
        end else begin
          rf_count++;
          last_rf_addr = mem_addr;
          mem_rdata = get_line(mem_addr);
        end
      end
    end else if (stray_ack) begin
      mem_ack = 1'b1;
    end
    #1;
  endtask

  // Runs one access until the stall drops and checks it against the reference.
  task automatic check_output(input logic rd, input logic wr, input logic byt,
                              input logic [31:0] a, input logic [31:0] wd);
    int           idx, wb0, rf0;
    logic         hit_exp, wb_exp;
    logic [31:0]  victim_addr, exp_rd;
    logic [127:0] victim_data;
    idx = int'(a[5:4]);
    hit_exp = mline[idx].valid && (mline[idx].tag == a[31:6]);
    wb_exp = !hit_exp && mline[idx].valid && mline[idx].dirty;
    victim_addr = {mline[idx].tag, a[5:4], 4'b0};
    victim_data = gold_line(victim_addr);
    exp_rd = byt ? {24'b0, gold_byte(a)} : gold_word(a);
    wb0 = wb_count;
    rf0 = rf_count;
    n_cyc = 0;
    do begin
      apply_stimulus(rd, wr, byt, a, wd);
      obs_req[n_cyc] = mem_req;
      obs_we[n_cyc] = mem_we;
      obs_addr[n_cyc] = mem_addr;
      obs_stall[n_cyc] = block_pipe_data_cache;
      n_cyc++;
    end while (block_pipe_data_cache && n_cyc < 60);
    check("access_done", block_pipe_data_cache, 1'b0);
    if (block_pipe_data_cache) return;
    check("stall_on_access", obs_stall[0], !hit_exp);
    check("refills", rf_count - rf0, hit_exp ? 0 : 1);
    check("writebacks", wb_count - wb0, wb_exp ? 1 : 0);
    if (wb_exp) begin
      check("wb_addr", last_wb_addr, victim_addr);
      check("wb_data", last_wb_data, victim_data);
    end
    if (!hit_exp) check("rf_addr", last_rf_addr, {a[31:4], 4'b0});
    if (rd && !wr) check("rdata", rdata, exp_rd);
    if (!hit_exp) begin
      mline[idx].valid = 1'b1;
      mline[idx].dirty = 1'b0;
      mline[idx].tag = a[31:6];
      model_misses++;
    end
    model_hits++;
    if (wr) apply_store(byt, a, wd);
  endtask

  task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
    check({tag, "_hit_count"}, hit_count, model_hits);
    check({tag, "_miss_count"}, miss_count, model_misses);
`endif
  endtask

  initial begin
    logic        rd, wr, byt;
    logic [31:0] a;
    int          kind;

    tv[0] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0,        1'b1, 32'h11111111};
    tv[1] = '{1'b0, 1'b1, 1'b0, 32'h108, 32'h87654321, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b0, 1'b1, 32'h10B, 32'h0,        1'b1, 32'h00000087};
    tv[3] = '{1'b1, 1'b0, 1'b1, 32'h108, 32'h0,        1'b1, 32'h00000021};
    tv[4] = '{1'b1, 1'b0, 1'b0, 32'h10A, 32'h0,        1'b1, 32'h87654321};
    tv[5] = '{1'b1, 1'b0, 1'b1, 32'h10D, 32'h0,        1'b1, 32'h00000033};
    tv[6] = '{1'b1, 1'b1, 1'b1, 32'h10C, 32'hFFFFFF5A, 1'b0, 32'h0};
    tv[7] = '{1'b1, 1'b0, 1'b0, 32'h10C, 32'h0,        1'b1, 32'h3333335A};
    tv[8] = '{1'b1, 1'b0, 1'b1, 32'h103, 32'h0,        1'b1, 32'h00000000};
    tv[9] = '{1'b1, 1'b0, 1'b1, 32'h106, 32'h0,        1'b1, 32'h00000011};

    reset = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; is_byte = 1'b0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset cycles with a pending load: every output must read zero
    rst_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
      check("rst_stall", block_pipe_data_cache, 1'b0);
      check("rst_req", mem_req, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 128'h0);
    end
    rst_req = 1'b0;
    model_reset();

    // Cold load, ack two cycles after the request rises
    preset_line(32'h100, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
    ack_lat = 2;
    check_output(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    check("cold_req_c0", obs_req[0], 1'b0);
    check("cold_req_c1", obs_req[1], 1'b1);
    check("cold_we_c1", obs_we[1], 1'b0);
    check("cold_addr_c1", obs_addr[1], 32'h100);
    check("cold_cycles", n_cyc, 4);

    // Back-to-back single-cycle hits from the table
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tv[i].rd, tv[i].wr, tv[i].byt, tv[i].a, tv[i].wd);
      check($sformatf("tv%0d_stall", i), block_pipe_data_cache, 1'b0);
      if (tv[i].chk) check($sformatf("tv%0d_rdata", i), rdata, tv[i].exp);
      if (tv[i].wr) apply_store(tv[i].byt, tv[i].a, tv[i].wd);
      model_hits++;
    end

    // Dirty eviction: writeback, one idle bus cycle, refill, hit
    check_output(1'b0, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF);
    ack_lat = 1;
    check_output(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
    check("dirty_we_c1", obs_we[1], 1'b1);
    check("dirty_addr_c1", obs_addr[1], 32'h100);
    check("dirty_wb_word1", last_wb_data[63:32], 32'hDEADBEEF);
    check("dirty_gap_c2", obs_req[2], 1'b0);
    check("dirty_req_c3", obs_req[3], 1'b1);
    check("dirty_we_c3", obs_we[3], 1'b0);
    check("dirty_addr_c3", obs_addr[3], 32'h140);
    check("dirty_cycles", n_cyc, 5);
    check_stats("seq");

    // Reset while the refill request is outstanding; no line is dirty here
    resp_en = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
    check("midrst_req_before", mem_req, 1'b1);
    rst_req = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
    check("midrst_req_during", mem_req, 1'b0);
    rst_req = 1'b0;
    model_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("midrst_req_after", mem_req, 1'b0);
    stray_ack = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    check("stray_stall", block_pipe_data_cache, 1'b0);
    check("stray_req", mem_req, 1'b0);
    stray_ack = 1'b0;
    resp_en = 1'b1;
    check_output(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    check("remiss_cycles", n_cyc, 3);

    // Read/write collision is a byte store; eviction carries it out
    check_output(1'b1, 1'b1, 1'b1, 32'h101, 32'h000000AB);
    ack_lat = 2;
    check_output(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
    check("collide_wb_byte1", last_wb_data[15:8], 8'hAB);
    check_stats("collide");

    // Randomized traffic against the reference memory
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        stray_ack = 1'($urandom_range(0, 1));
        apply_stimulus(1'b0, 1'b0, 1'b0, $urandom, $urandom);
        check("idle_stall", block_pipe_data_cache, 1'b0);
        check("idle_req", mem_req, 1'b0);
        stray_ack = 1'b0;
      end
      ack_lat = $urandom_range(1, 4);
      kind = $urandom_range(0, 3);
      rd = (kind != 2);
      wr = (kind >= 2);
      byt = 1'($urandom_range(0, 1));
      a = 32'h1000 | 32'($urandom_range(0, 511));
      check_output(rd, wr, byt, a, $urandom);
    end
    check_stats("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
